// File: rtl/text_console_pkg.sv
// Shared definitions for the text console command processor: opcodes,
// FSM state encoding, character codes and cell/BCD helper functions.
package text_console_pkg;

    localparam logic [3:0] OP_NOP    = 4'd0;
    localparam logic [3:0] OP_SCROLL = 4'd1;
    localparam logic [3:0] OP_CLEAR  = 4'd2;
    localparam logic [3:0] OP_DEC    = 4'd3;
    localparam logic [3:0] OP_HEX    = 4'd4;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SCROLL_CLR = 3'd1,
        ST_FIELD_CLR  = 3'd2,
        ST_CONVERT    = 3'd3,
        ST_FIELD_WR   = 3'd4
    } state_e;

    localparam logic [7:0] CH_ZERO  = 8'd48;
    localparam logic [7:0] CH_A     = 8'd65;
    localparam logic [7:0] CH_MINUS = 8'd45;
    localparam logic [7:0] CH_SPACE = 8'd32;

    // Character-buffer word: colour in the top 12 bits, character in the low byte.
    function automatic logic [31:0] pack_cell(input logic [11:0] color, input logic [7:0] ch);
        return {color, 12'd0, ch};
    endfunction

    // Uppercase ASCII for one hex nibble.
    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return CH_ZERO + {4'd0, nib};
        end else begin
            return CH_A + {4'd0, nib} - 8'd10;
        end
    endfunction

    // Double-dabble correction: add 3 to every BCD digit that is 5 or more.
    function automatic logic [39:0] bcd_adjust(input logic [39:0] v);
        logic [39:0] r;
        r = v;
        for (int i = 0; i < 10; i++) begin
            if (r[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = r[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = r[4*i +: 4];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/text_console_ctrl_if.sv
// Command and cell-write bundle of the text console controller.
// master = command source / buffer side, slave = the controller.
interface text_console_ctrl_if #(
    parameter int COLS = 160,
    parameter int ROWS = 45
);
    localparam int XW = $clog2(COLS);
    localparam int YW = $clog2(ROWS);

    logic          cmd_valid;
    logic          cmd_ready;
    logic [3:0]    cmd_op;
    logic [7:0]    cmd_x;
    logic [7:0]    cmd_y;
    logic [11:0]   cmd_color;
    logic [31:0]   cmd_num;
    logic          wr_en;
    logic [XW-1:0] wr_x;
    logic [YW-1:0] wr_y;
    logic [31:0]   wr_data;
    logic [YW-1:0] scroll_offset;

    modport master (
        output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_color, cmd_num,
        input  cmd_ready, wr_en, wr_x, wr_y, wr_data, scroll_offset
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_color, cmd_num,
        output cmd_ready, wr_en, wr_x, wr_y, wr_data, scroll_offset
    );
endinterface

// File: rtl/text_console_ctrl_bin2bcd.sv
// bin2bcd_seq: sequential double-dabble converter. Loads |i_num| on i_start,
// shifts one bit per cycle, and pulses o_done 33 cycles after the start edge.
module bin2bcd_seq
    import text_console_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic [31:0] i_num,
    output logic        o_done,
    output logic [39:0] o_bcd,
    output logic        o_neg
);
    logic [31:0] r_bin;
    logic [39:0] r_bcd;
    logic        r_neg;
    logic        r_busy;
    logic        r_done;
    logic [5:0]  r_cnt;
    logic [31:0] w_mag;
    logic [39:0] w_adj;

    // Magnitude of the signed input (-2^31 maps to 2^31) and the per-step digit correction.
    always_comb begin
        w_mag = i_num[31] ? (~i_num + 32'd1) : i_num;
        w_adj = bcd_adjust(r_bcd);
    end

    // 32 shift steps, then one cycle to raise done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin  <= 32'd0;
            r_bcd  <= 40'd0;
            r_neg  <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_cnt  <= 6'd0;
        end else if (i_start) begin
            r_bin  <= w_mag;
            r_bcd  <= 40'd0;
            r_neg  <= i_num[31];
            r_busy <= 1'b1;
            r_done <= 1'b0;
            r_cnt  <= 6'd0;
        end else if (r_busy) begin
            if (r_cnt == 6'd32) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end else begin
                r_bcd <= {w_adj[38:0], r_bin[31]};
                r_bin <= {r_bin[30:0], 1'b0};
                r_cnt <= r_cnt + 6'd1;
            end
        end else begin
            r_done <= 1'b0;
        end
    end

    assign o_done = r_done;
    assign o_bcd  = r_bcd;
    assign o_neg  = r_neg;
endmodule

// File: rtl/text_console_ctrl.sv
// text_console_ctrl: turns SCROLL / CLEAR / DEC / HEX commands into single-cell
// writes to the character buffer and owns the scanout scroll offset.
// Optional feature: define TEXT_CONSOLE_HEX_EN to enable the HEX opcode;
// without it opcode 4 behaves as a NOP and no hex path is built.
module text_console_ctrl
    import text_console_pkg::*;
#(
    parameter int COLS    = 160,
    parameter int ROWS    = 45,
    parameter int FIELD_W = 12
) (
    input  logic clk,
    input  logic rst_n,
    text_console_ctrl_if.slave bus
);
    localparam int XW = $clog2(COLS);
    localparam int YW = $clog2(ROWS);
    localparam int CW = $clog2(COLS + FIELD_W + 1);

    localparam logic [CW-1:0] CNT_COLS  = CW'(COLS);
    localparam logic [CW-1:0] CNT_FW    = CW'(FIELD_W);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [XW-1:0] X_LAST    = XW'(COLS - 1);
    localparam logic [XW-1:0] X_FW_LAST = XW'(FIELD_W - 1);
    localparam logic [YW-1:0] Y_LAST    = YW'(ROWS - 1);
    localparam logic [7:0]    CMD_Y_MAX = 8'(ROWS - 1);
    localparam logic [7:0]    CMD_X_MAX = 8'(COLS / FIELD_W - 1);
    localparam logic [8:0]    ROWS9     = 9'(ROWS);

    state_e        r_state, w_state_nx;
    logic [CW-1:0] r_cnt, w_cnt_nx;
    logic          r_wr_en, w_wr_en_nx;
    logic [XW-1:0] r_wr_x, w_wr_x_nx;
    logic [YW-1:0] r_wr_y, w_wr_y_nx;
    logic [31:0]   r_wr_data, w_wr_data_nx;
    logic [YW-1:0] r_offset, w_offset_nx, w_offset_inc;
    logic          w_accept, w_start;

    logic [YW-1:0] r_row;
    logic [XW-1:0] r_base_x;
    logic [11:0]   r_color;
    logic [7:0]    w_ymin, w_xc;
    logic [8:0]    w_ysum;
    logic [YW-1:0] w_phys_row;
    logic [XW-1:0] w_base_x, w_fld_x;

    logic          w_done, w_neg;
    logic [39:0]   w_bcd;
    int            w_ndig, w_pos;
    logic [3:0]    w_digit;
    logic [7:0]    w_dec_ch, w_ch;
`ifdef TEXT_CONSOLE_HEX_EN
    logic          r_hex;
    logic [31:0]   r_num;
    logic [7:0]    w_hex_ch;
`endif

    bin2bcd_seq u_bcd (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_start),
        .i_num   (bus.cmd_num),
        .o_done  (w_done),
        .o_bcd   (w_bcd),
        .o_neg   (w_neg)
    );

    // Command geometry: clamped row/field index, physical row, field base column, next offset.
    always_comb begin
        w_ymin       = (bus.cmd_y > CMD_Y_MAX) ? CMD_Y_MAX : bus.cmd_y;
        w_ysum       = {1'b0, w_ymin} + 9'(r_offset);
        w_phys_row   = (w_ysum >= ROWS9) ? YW'(w_ysum - ROWS9) : YW'(w_ysum);
        w_xc         = (bus.cmd_x > CMD_X_MAX) ? CMD_X_MAX : bus.cmd_x;
        w_base_x     = XW'(int'(w_xc) * FIELD_W);
        w_offset_inc = (r_offset == Y_LAST) ? {YW{1'b0}} : r_offset + YW'(1);
        w_fld_x      = r_base_x + (X_FW_LAST - XW'(r_cnt));
    end

    // Character for field position r_cnt, counted from the right-hand cell.
    always_comb begin
        w_ndig = 1;
        for (int i = 0; i < 10; i++) begin
            w_ndig = (w_bcd[4*i +: 4] != 4'd0) ? i + 1 : w_ndig;
        end
        w_pos   = int'(r_cnt);
        w_digit = 4'(w_bcd >> (4 * w_pos));
        if (w_pos < w_ndig) begin
            w_dec_ch = CH_ZERO + {4'd0, w_digit};
        end else if (w_pos == w_ndig) begin
            w_dec_ch = w_neg ? CH_MINUS : CH_SPACE;
        end else begin
            w_dec_ch = CH_SPACE;
        end
`ifdef TEXT_CONSOLE_HEX_EN
        w_hex_ch = (w_pos < 8) ? hex_ascii(4'(r_num >> (4 * w_pos))) : CH_SPACE;
        w_ch     = r_hex ? w_hex_ch : w_dec_ch;
`else
        w_ch     = w_dec_ch;
`endif
    end

    // Next-state and next-output logic; each busy state emits one cell per cycle.
    always_comb begin
        w_state_nx   = r_state;
        w_cnt_nx     = r_cnt;
        w_wr_en_nx   = 1'b0;
        w_wr_x_nx    = r_wr_x;
        w_wr_y_nx    = r_wr_y;
        w_wr_data_nx = r_wr_data;
        w_offset_nx  = r_offset;
        w_accept     = 1'b0;
        w_start      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    w_accept = 1'b1;
                    w_cnt_nx = {CW{1'b0}};
                    case (bus.cmd_op)
                        OP_SCROLL: begin
                            w_state_nx  = ST_SCROLL_CLR;
                            w_offset_nx = w_offset_inc;
                        end
                        OP_CLEAR: w_state_nx = ST_FIELD_CLR;
                        OP_DEC: begin
                            w_state_nx = ST_CONVERT;
                            w_start    = 1'b1;
                        end
`ifdef TEXT_CONSOLE_HEX_EN
                        OP_HEX:   w_state_nx = ST_FIELD_WR;
                        OP_NOP:   w_state_nx = ST_IDLE;
`else
                        OP_NOP, OP_HEX: w_state_nx = ST_IDLE;
`endif
                        default:  w_state_nx = ST_IDLE;
                    endcase
                end else begin
                    w_accept = 1'b0;
                end
            end
            ST_SCROLL_CLR: begin
                if (r_cnt == CNT_COLS) begin
                    w_state_nx = ST_IDLE;
                end else begin
                    w_wr_en_nx   = 1'b1;
                    w_wr_x_nx    = X_LAST - XW'(r_cnt);
                    w_wr_y_nx    = r_row;
                    w_wr_data_nx = 32'd0;
                    w_cnt_nx     = r_cnt + CNT_ONE;
                end
            end
            ST_FIELD_CLR: begin
                if (r_cnt == CNT_FW) begin
                    w_state_nx = ST_IDLE;
                end else begin
                    w_wr_en_nx   = 1'b1;
                    w_wr_x_nx    = w_fld_x;
                    w_wr_y_nx    = r_row;
                    w_wr_data_nx = 32'd0;
                    w_cnt_nx     = r_cnt + CNT_ONE;
                end
            end
            ST_CONVERT: begin
                // The first cell goes out on the same edge that sees done.
                if (w_done) begin
                    w_wr_en_nx   = 1'b1;
                    w_wr_x_nx    = w_fld_x;
                    w_wr_y_nx    = r_row;
                    w_wr_data_nx = pack_cell(r_color, w_ch);
                    w_cnt_nx     = r_cnt + CNT_ONE;
                    w_state_nx   = ST_FIELD_WR;
                end else begin
                    w_state_nx = ST_CONVERT;
                end
            end
            ST_FIELD_WR: begin
                if (r_cnt == CNT_FW) begin
                    w_state_nx = ST_IDLE;
                end else begin
                    w_wr_en_nx   = 1'b1;
                    w_wr_x_nx    = w_fld_x;
                    w_wr_y_nx    = r_row;
                    w_wr_data_nx = pack_cell(r_color, w_ch);
                    w_cnt_nx     = r_cnt + CNT_ONE;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    // State, counter, scroll offset and registered write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= {CW{1'b0}};
            r_wr_en   <= 1'b0;
            r_wr_x    <= {XW{1'b0}};
            r_wr_y    <= {YW{1'b0}};
            r_wr_data <= 32'd0;
            r_offset  <= {YW{1'b0}};
        end else begin
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_wr_en   <= w_wr_en_nx;
            r_wr_x    <= w_wr_x_nx;
            r_wr_y    <= w_wr_y_nx;
            r_wr_data <= w_wr_data_nx;
            r_offset  <= w_offset_nx;
        end
    end

    // Operand capture on accept; SCROLL clears the row at the pre-advance offset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row    <= {YW{1'b0}};
            r_base_x <= {XW{1'b0}};
            r_color  <= 12'd0;
`ifdef TEXT_CONSOLE_HEX_EN
            r_hex    <= 1'b0;
            r_num    <= 32'd0;
`endif
        end else if (w_accept) begin
            r_row    <= (bus.cmd_op == OP_SCROLL) ? r_offset : w_phys_row;
            r_base_x <= w_base_x;
            r_color  <= bus.cmd_color;
`ifdef TEXT_CONSOLE_HEX_EN
            r_hex    <= (bus.cmd_op == OP_HEX);
            r_num    <= bus.cmd_num;
`endif
        end
    end

    assign bus.cmd_ready     = (r_state == ST_IDLE);
    assign bus.wr_en         = r_wr_en;
    assign bus.wr_x          = r_wr_x;
    assign bus.wr_y          = r_wr_y;
    assign bus.wr_data       = r_wr_data;
    assign bus.scroll_offset = r_offset;
endmodule

// File: tb/tb_text_console_ctrl.sv
// Directed testbench for text_console_ctrl (COLS=160, ROWS=45, FIELD_W=12).
// HEX expectations follow TEXT_CONSOLE_HEX_EN.
module tb_text_console_ctrl;
    import text_console_pkg::*;

    localparam int COLS = 160;
    localparam int ROWS = 45;
    localparam int FW   = 12;
    localparam int LOGN = 16384;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    text_console_ctrl_if #(.COLS(COLS), .ROWS(ROWS)) bus ();

    text_console_ctrl #(.COLS(COLS), .ROWS(ROWS), .FIELD_W(FW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int n_wr     = 0;
    int t0       = 0;
    int wbase    = 0;
    int log_x [LOGN];
    int log_y [LOGN];
    int log_c [LOGN];
    logic [31:0] log_d [LOGN];

    // Free-running edge counter.
    always @(posedge clk) cyc <= cyc + 1;

    // Record every cell write, sampled on the falling edge.
    always @(negedge clk) begin
        if (bus.wr_en) begin
            log_x[n_wr % LOGN] <= int'(bus.wr_x);
            log_y[n_wr % LOGN] <= int'(bus.wr_y);
            log_c[n_wr % LOGN] <= cyc;
            log_d[n_wr % LOGN] <= bus.wr_data;
            n_wr <= n_wr + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one command for one accept edge; t0 = accept edge, wbase = write log start.
    task automatic send(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y,
                        input logic [11:0] color, input logic [31:0] num);
        @(negedge clk);
        check_eq("ready_before_cmd", 64'(bus.cmd_ready), 64'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_x     = x;
        bus.cmd_y     = y;
        bus.cmd_color = color;
        bus.cmd_num   = num;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        t0    = cyc;
        wbase = n_wr;
    endtask

    task automatic wait_idle(input string tag, input int exp_cyc, input int budget);
        int k;
        k = 0;
        while (!bus.cmd_ready && k < budget) begin
            @(negedge clk);
            k++;
        end
        check_eq(tag, 64'(cyc - t0), 64'(exp_cyc));
    endtask

    // chars lists the field in cell order 0..n-1; an empty string means blank (0) cells.
    task automatic verify_writes(input string tag, input int n_exp, input int x_first, input int y_exp,
                                 input int c_first, input string chars, input logic [11:0] color);
        int idx;
        int f0;
        logic [31:0] ed;
        check_eq({tag, "_count"}, 64'(n_wr - wbase), 64'(n_exp));
        for (int i = 0; i < n_exp; i++) begin
            if (i >= n_wr - wbase) break;
            idx = (wbase + i) % LOGN;
            if (chars.len() == 0) ed = 32'd0;
            else ed = {color, 12'd0, 8'(chars[n_exp - 1 - i])};
            f0 = n_checks - n_pass;
            check_eq({tag, "_x"},     64'(log_x[idx]), 64'(x_first - i));
            check_eq({tag, "_y"},     64'(log_y[idx]), 64'(y_exp));
            check_eq({tag, "_data"},  64'(log_d[idx]), 64'(ed));
            check_eq({tag, "_cycle"}, 64'(log_c[idx] - t0), 64'(c_first + i));
            if (n_checks - n_pass != f0) break;
        end
    endtask

    initial begin
        int acc [3];
        int n_acc;
        int k;
        logic [5:0] prev;

        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 4'd0;
        bus.cmd_x     = 8'd0;
        bus.cmd_y     = 8'd0;
        bus.cmd_color = 12'd0;
        bus.cmd_num   = 32'd0;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_ready",  64'(bus.cmd_ready),     64'd1);
        check_eq("rst_wr_en",  64'(bus.wr_en),         64'd0);
        check_eq("rst_wr_x",   64'(bus.wr_x),          64'd0);
        check_eq("rst_wr_y",   64'(bus.wr_y),          64'd0);
        check_eq("rst_wr_data",64'(bus.wr_data),       64'd0);
        check_eq("rst_offset", 64'(bus.scroll_offset), 64'd0);
        rst_n = 1'b1;

        // NOP and an unknown opcode: accepted, no writes, stays idle
        send(OP_NOP, 8'd0, 8'd0, 12'hFFF, 32'd5);
        check_eq("nop_ready", 64'(bus.cmd_ready), 64'd1);
        repeat (4) @(negedge clk);
        check_eq("nop_writes", 64'(n_wr - wbase), 64'd0);
        send(4'd9, 8'd1, 8'd1, 12'hFFF, 32'd5);
        check_eq("unk_ready", 64'(bus.cmd_ready), 64'd1);
        repeat (4) @(negedge clk);
        check_eq("unk_writes", 64'(n_wr - wbase), 64'd0);

        // First SCROLL: offset 0 -> 1, clears row 0 right to left
        send(OP_SCROLL, 8'd0, 8'd0, 12'h000, 32'd0);
        check_eq("scroll_off_1", 64'(bus.scroll_offset), 64'd1);
        wait_idle("scroll_ready", 161, 400);
        verify_writes("scroll0", 160, 159, 0, 1, "", 12'h000);

        // 44 more SCROLLs: offset wraps 44 -> 0, last clear on row 44
        for (int s = 1; s < 45; s++) begin
            send(OP_SCROLL, 8'd0, 8'd0, 12'h000, 32'd0);
            check_eq("scroll_off", 64'(bus.scroll_offset), 64'((s + 1) % ROWS));
            wait_idle("scroll_ready_n", 161, 400);
            if (s == 44) verify_writes("scroll44", 160, 159, 44, 1, "", 12'h000);
        end

        // Back-to-back SCROLLs with cmd_valid held high
        @(negedge clk);
        prev          = bus.scroll_offset;
        bus.cmd_op    = OP_SCROLL;
        bus.cmd_valid = 1'b1;
        n_acc = 0;
        k     = 0;
        while (n_acc < 3 && k < 1000) begin
            @(negedge clk);
            k++;
            if (bus.scroll_offset != prev) begin
                acc[n_acc] = cyc;
                n_acc++;
                prev = bus.scroll_offset;
            end
        end
        bus.cmd_valid = 1'b0;
        t0    = cyc;
        wbase = n_wr;
        check_eq("b2b_accepts", 64'(n_acc), 64'd3);
        check_eq("b2b_gap1", 64'(acc[1] - acc[0]), 64'd162);
        check_eq("b2b_gap2", 64'(acc[2] - acc[1]), 64'd162);
        check_eq("b2b_offset", 64'(bus.scroll_offset), 64'd3);
        wait_idle("b2b_ready", 161, 400);
        verify_writes("b2b", 160, 159, 2, 1, "", 12'h000);

        // DEC -305 at field 1, row 2 (+offset 3 -> physical row 5)
        send(OP_DEC, 8'd1, 8'd2, 12'hF00, -32'sd305);
        wait_idle("dec_ready", 46, 100);
        verify_writes("dec_m305", 12, 23, 5, 34, "        -305", 12'hF00);

        // DEC 0
        send(OP_DEC, 8'd0, 8'd0, 12'h0F0, 32'd0);
        wait_idle("dec0_ready", 46, 100);
        verify_writes("dec_zero", 12, 11, 3, 34, "           0", 12'h0F0);

        // DEC -2^31 with clamped x (50 -> 12, base 144) and y (200 -> 44, row 2)
        send(OP_DEC, 8'd50, 8'd200, 12'h0A5, 32'h8000_0000);
        wait_idle("decmin_ready", 46, 100);
        verify_writes("dec_min", 12, 155, 2, 34, " -2147483648", 12'h0A5);

        // DEC ten-digit positive
        send(OP_DEC, 8'd2, 8'd7, 12'h123, 32'd1234567890);
        wait_idle("decbig_ready", 46, 100);
        verify_writes("dec_big", 12, 35, 10, 34, "  1234567890", 12'h123);

        // CLEAR field 3, row 1 -> physical row 4
        send(OP_CLEAR, 8'd3, 8'd1, 12'hABC, 32'd0);
        wait_idle("clr_ready", 13, 100);
        verify_writes("clear", 12, 47, 4, 1, "", 12'h000);

        // HEX
`ifdef TEXT_CONSOLE_HEX_EN
        send(OP_HEX, 8'd0, 8'd0, 12'h0FF, 32'h00AB_12CD);
        wait_idle("hex_ready", 13, 100);
        verify_writes("hex", 12, 11, 3, 1, "    00AB12CD", 12'h0FF);
`else
        send(OP_HEX, 8'd0, 8'd0, 12'h0FF, 32'h00AB_12CD);
        check_eq("hexoff_ready", 64'(bus.cmd_ready), 64'd1);
        repeat (15) @(negedge clk);
        check_eq("hexoff_writes", 64'(n_wr - wbase), 64'd0);
`endif

        // Reset in the middle of a DEC conversion
        send(OP_DEC, 8'd0, 8'd0, 12'hFFF, 32'd12345);
        while (cyc - t0 < 10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_wr_en",  64'(bus.wr_en),         64'd0);
        check_eq("mid_rst_ready",  64'(bus.cmd_ready),     64'd1);
        check_eq("mid_rst_offset", 64'(bus.scroll_offset), 64'd0);
        check_eq("mid_rst_data",   64'(bus.wr_data),       64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        check_eq("mid_rst_writes", 64'(n_wr - wbase), 64'd0);
        check_eq("mid_rst_ready2", 64'(bus.cmd_ready), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/text_console_ctrl.md
# text_console_ctrl

Command processor for the character-cell text console. It accepts scroll, field-clear and number-print commands over a valid/ready handshake and turns each into a sequence of single-cell writes to the VGA character buffer. It owns the scroll offset the VGA scanout uses. It is the parametrised successor of the fixed 160x45 display controller, adding configurable geometry, a proper handshake, full-field redraw, per-command colour, hex printing and an asynchronous reset.

## Interface
- COLS, 160, character columns in the buffer
- ROWS, 45, character rows in the buffer
- FIELD_W, 12, cells per number field; must be ≥ 12
- XW = $clog2(COLS), YW = $clog2(ROWS), derived widths; not overridable
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller idle; a command is accepted on a clk edge where cmd_valid && cmd_ready
- cmd_op  in  4  opcode: 0 NOP, 1 SCROLL, 2 CLEAR, 3 DEC, 4 HEX
- cmd_x  in  8  field index; base column is cmd_x*FIELD_W
- cmd_y  in  8  logical row
- cmd_color  in  12  RGB444 foreground colour for DEC/HEX
- cmd_num  in  32  value; two's complement for DEC
- wr_en  out  1  cell write strobe, one cell per cycle
- wr_x  out  XW  cell column
- wr_y  out  YW  physical cell row
- wr_data  out  32  {color[11:0], 12'd0, char[7:0]}; 32'd0 means blank
- scroll_offset  out  YW  physical row shown first

## Operation
- States: IDLE, SCROLL_CLR, FIELD_CLR, CONVERT, FIELD_WR. cmd_ready = (state == IDLE).
- Operands are sampled only on accept. cmd_valid while busy is ignored.
- The physical row is (min(cmd_y, ROWS-1) + scroll_offset) mod ROWS.
- cmd_x is clamped to COLS/FIELD_W - 1, so a field never wraps.
- NOP and unknown opcodes: accepted with no effect. The block stays in IDLE.
- SCROLL: on accept, scroll_offset advances by 1 and wraps from ROWS-1 to 0. The row equal to the old offset is then cleared. The block writes COLS cells, columns COLS-1 down to 0, each with wr_data = 0.
- CLEAR: writes FIELD_W cells with wr_data = 0, from field cell FIELD_W-1 down to 0.
- DEC: the magnitude is converted to 10 BCD digits by bin2bcd_seq. -2^31 gives 2147483648.
  - The field is then rewritten entirely, right-justified, in cell order FIELD_W-1 down to 0.
  - Content, right to left: significant digits (at least one, so 0 prints "0"), then the sign cell ('-' or ' '), then spaces up to cell 0.
- HEX: no conversion. The field is rewritten with 8 uppercase hex digits, zero-padded and unsigned, at cells FIELD_W-1..FIELD_W-8, with spaces to the left.
- Character codes: '0'=48, 'A'=65, '-'=45, ' '=32.
- Every character written by DEC/HEX, including spaces, carries cmd_color.

## Timing
- Reset values: state IDLE, cmd_ready 1, wr_en 0, wr_x 0, wr_y 0, wr_data 0, scroll_offset 0, converter idle.
- Accept edge = cycle 0.
- SCROLL: scroll_offset is updated at cycle 0. wr_en is high for cycles 1..COLS. cmd_ready is high again at cycle COLS+1.
- CLEAR / HEX: wr_en is high for cycles 1..FIELD_W. cmd_ready rises at FIELD_W+1.
- DEC: the converter starts at cycle 0 and reports done at cycle 33. wr_en is high for cycles 34..33+FIELD_W. cmd_ready rises at 34+FIELD_W.
- wr_en is never high in IDLE. Write outputs are registered.
- Reset asserted mid-command: all outputs return to their reset values immediately. Cells already written stay as they are.
- Back-to-back commands: a command presented with cmd_valid held high is accepted on the first edge where cmd_ready is high. There are no bubble cycles beyond the ones stated above.

## Configuration
- TEXT_CONSOLE_HEX_EN defined: opcode 4 prints hex as specified.
- TEXT_CONSOLE_HEX_EN undefined: opcode 4 is treated as an unknown opcode (a NOP), and the hex digit path is not synthesised.

## Structure
- Package text_console_pkg holds:
  - opcode localparams
  - state encodings
  - character constants
  - the wr_data packing function
- Sub-module bin2bcd_seq is a sequential double-dabble converter: 32-bit signed in, 40-bit BCD plus sign out, start/done handshake, 33-cycle latency.

## Test plan
- Reset, then SCROLL with COLS=160: scroll_offset 0→1; 160 writes at wy=0, wx from 159 down to 0, data 0; cmd_ready returns at cycle 161.
- 45 SCROLLs with ROWS=45: scroll_offset wraps 44→0; the last clear hits row 44.
- DEC x=1, y=2, offset 3, color 12'hF00, num -305 → 12 writes at row 5, cols 23..12, chars '5','0','3','-' then 8 spaces, each wr_data[31:20]=12'hF00.
- DEC num 0 → cell 11 '0', cell 10 ' ', rest spaces; DEC -2147483648 → "2147483648" then '-'.
- HEX (macro defined) num 32'h00AB12CD → "00AB12CD" at cells 4..11, spaces at 0..3; with the macro undefined → no writes, cmd_ready still high.
- Drop rst_n during a DEC conversion at cycle 10 → wr_en 0 and cmd_ready 1 immediately, scroll_offset 0, no further writes.
